// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        PAUSE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dec2a4_oh.sv
// 2-to-4 one-hot decoder; feeds the registered grant vector.
module dec2a4_oh
    import arb_pkg::*;
(
    input  logic [1:0]       idx,
    output logic [N_REQ-1:0] oh
);

    // Set exactly the bit selected by idx.
    always_comb begin
        oh      = '0;
        oh[idx] = 1'b1;
    end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Four-requester round-robin arbiter with optional per-grant hold limit.
// The owner index is registered and the one-hot grant is its registered decode,
// so there is no combinational path from req to gnt.
module arb4_rr_ctrl
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_vld
);

    arb_state_e       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] idx_oh;
    logic [2:0]       pick;

    // Rotate-and-search: first set request starting at index p, wrapping mod 4.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        for (int i = 0; i < N_REQ; i++) begin
            c = p + 2'(i);
            if (!res[2] && r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    // Next owner, search pointer, hold counter and state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        pick       = 3'b000;
        case (state_q)
            GRANT: begin
                if (!req[idx_q]) begin
                    // Owner let go: rotate past it and hand off in the same cycle.
                    ptr_d = idx_q + 2'd1;
                    pick  = rr_pick(req, idx_q + 2'd1);
                    if (pick[2]) begin
                        state_d    = GRANT;
                        idx_d      = pick[1:0];
                        hold_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (HOLD_MAX != 0 && hold_cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    // Hold limit reached: force one empty cycle before re-arbitrating.
                    ptr_d      = idx_q + 2'd1;
                    state_d    = PAUSE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE and PAUSE arbitrate identically from the stored pointer.
                pick = rr_pick(req, ptr_q);
                if (pick[2]) begin
                    state_d    = GRANT;
                    idx_d      = pick[1:0];
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    dec2a4_oh u_dec (
        .idx (idx_d),
        .oh  (idx_oh)
    );

    // Grant is live only in cycles spent in GRANT.
    always_comb begin
        gnt_d = (state_d == GRANT) ? idx_oh : '0;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'b00;
            idx_q      <= 2'b00;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Scoreboard bench for arb4_rr_ctrl: one instance with HOLD_MAX=8, one with HOLD_MAX=2.
module tb_arb4_rr_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8_n, rst2_n;
    logic [3:0] req8, req2, gnt8, gnt2;
    logic [1:0] idx8, idx2;
    logic       vld8, vld2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        int         d;
        logic [3:0] g;
        string      nm;
    } sb_t;

    sb_t sb[$];
    sb_t e;

    // Expected grants for req=1111 with HOLD_MAX=2: 2 cycles each, one gap, order 0,1,2,3,0.
    localparam logic [3:0] ROT [14] = '{4'b0001, 4'b0001, 4'b0000,
                                        4'b0010, 4'b0010, 4'b0000,
                                        4'b0100, 4'b0100, 4'b0000,
                                        4'b1000, 4'b1000, 4'b0000,
                                        4'b0001, 4'b0001};

    arb4_rr_ctrl #(.HOLD_MAX(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst8_n), .req(req8), .gnt(gnt8), .gnt_idx(idx8), .gnt_vld(vld8)
    );

    arb4_rr_ctrl #(.HOLD_MAX(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .req(req2), .gnt(gnt2), .gnt_idx(idx2), .gnt_vld(vld2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check_dut(input string nm, input int d, input logic [3:0] eg);
        logic [3:0] ag;
        logic [1:0] ai;
        logic       av;
        ag = (d == 8) ? gnt8 : gnt2;
        ai = (d == 8) ? idx8 : idx2;
        av = (d == 8) ? vld8 : vld2;
        checks++;
        if (ag !== eg || av !== (|eg) || ((|eg) && ai !== enc(eg))) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
                     nm, d, $time, ag, ai, av, eg, enc(eg), |eg);
        end
    endtask

    task automatic check_idx0(input string nm, input logic [1:0] ai);
        checks++;
        if (ai !== 2'd0) begin
            errors++;
            $display("FAIL %s: got gnt_idx=%0d, want 0", nm, ai);
        end
    endtask

    // Drive one cycle of req and queue the grant expected after the sampling edge.
    task automatic step(input string nm, input int d, input logic [3:0] r, input logic [3:0] eg);
        sb_t s;
        if (d == 8) req8 = r;
        else        req2 = r;
        s.due = cyc + 1;
        s.d   = d;
        s.g   = eg;
        s.nm  = nm;
        sb.push_back(s);
        @(posedge clk);
        #1;
    endtask

    // Monitor: invariants every cycle, then retire scoreboard entries due now.
    always @(negedge clk) begin
        checks++;
        if ($countones(gnt8) > 1 || vld8 !== (|gnt8) || $countones(gnt2) > 1 || vld2 !== (|gnt2)) begin
            errors++;
            $display("FAIL invariant t=%0t: gnt8=%b vld8=%b gnt2=%b vld2=%b, want onehot0 and vld==|gnt",
                     $time, gnt8, vld8, gnt2, vld2);
        end
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s late: due cycle %0d, now %0d", e.nm, e.due, cyc);
            end else begin
                check_dut(e.nm, e.d, e.g);
            end
        end
    end

    initial begin
        rst8_n = 1'b0;
        rst2_n = 1'b0;
        req8   = 4'b1111;
        req2   = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check_dut("reset", 8, 4'b0000);
        check_dut("reset", 2, 4'b0000);
        check_idx0("reset_idx", idx8);

        // Single request, held.
        rst8_n = 1'b1;
        repeat (4) step("single", 8, 4'b0100, 4'b0100);
        step("single_rel", 8, 4'b0000, 4'b0000);            // ptr -> 3

        // Zero-gap handoff: owner 1 drops with 1001 pending, ptr=2 picks 3.
        step("handoff", 8, 4'b0010, 4'b0010);
        step("handoff", 8, 4'b1011, 4'b0010);
        step("handoff", 8, 4'b1001, 4'b1000);
        step("handoff", 8, 4'b1001, 4'b1000);
        step("handoff", 8, 4'b0001, 4'b0001);
        step("handoff", 8, 4'b0000, 4'b0000);               // ptr -> 1

        // Sole requester: 8 on, 1 off, repeat.
        for (int i = 0; i < 20; i++)
            step("sole_timeout", 8, 4'b0010, (i % 9 == 8) ? 4'b0000 : 4'b0010);
        step("sole_rel", 8, 4'b0000, 4'b0000);              // ptr -> 2

        // Owner drops exactly on its 9th cycle: direct handoff, no pause.
        for (int i = 0; i < 8; i++) step("limit", 8, 4'b0101, 4'b0100);
        step("limit_handoff", 8, 4'b0001, 4'b0001);
        step("limit_rel", 8, 4'b0000, 4'b0000);             // ptr -> 1

        // Asynchronous reset while gnt=1000.
        step("amg", 8, 4'b1000, 4'b1000);
        step("amg", 8, 4'b1000, 4'b1000);
        @(negedge clk);
        #1;
        rst8_n = 1'b0;
        #1;
        check_dut("async_rst", 8, 4'b0000);
        check_idx0("async_rst_idx", idx8);
        @(posedge clk);
        #1;
        rst8_n = 1'b1;
        step("post_rst", 8, 4'b1010, 4'b0010);
        step("post_rst", 8, 4'b0000, 4'b0000);

        // Round-robin rotation on the HOLD_MAX=2 instance.
        rst2_n = 1'b1;
        for (int i = 0; i < 14; i++) step("rotation", 2, 4'b1111, ROT[i]);
        step("rotation_rel", 2, 4'b0000, 4'b0000);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
